// File: rtl/conv_kernel_mac.sv
// rtl/conv_kernel_mac.sv - K x K signed convolution MAC, one column per cycle, with shift, saturation and optional ReLU
module conv_kernel_mac #(
   parameter int K     = 5,
   parameter int DW    = 9,
   parameter int ACCW  = 2*DW + $clog2(K*K) + 1,
   parameter int SHIFT = 4
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              x_valid,
   output logic              x_ready,
   input  logic [K*K*DW-1:0] x_win,
   input  logic [K*K*DW-1:0] w_win,
   input  logic [DW-1:0]     bias,
   input  logic              relu_en,
   output logic              conv_valid,
   input  logic              conv_ready,
   output logic [DW-1:0]     conv_data
);

   // Counter runs 0..K: K column cycles plus one drain cycle for the registered column sum.
   localparam int CW = $clog2(K+1);

   localparam logic signed [ACCW:0] SAT_MAX = (ACCW+1)'((64'sd1 <<< (DW-1)) - 64'sd1);
   localparam logic signed [ACCW:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

   state_t                   state;
   logic [CW-1:0]            c_cnt;
   logic signed [ACCW-1:0]   acc;
   logic signed [ACCW-1:0]   col_q;
   logic signed [ACCW-1:0]   col_sum;
   logic [K*K*DW-1:0]        x_q;
   logic [K*K*DW-1:0]        w_q;
   logic signed [DW-1:0]     bias_q;
   logic                     relu_q;
   logic signed [ACCW:0]     total;
   logic signed [ACCW:0]     shifted;
   logic signed [DW-1:0]     result;

   function automatic logic signed [ACCW-1:0] mul_ext(input logic signed [DW-1:0] a,
                                                      input logic signed [DW-1:0] b);
      logic signed [2*DW-1:0] p;
      p = a * b;
      return ACCW'(p);
   endfunction

   // Sum of the K products in the column selected by c_cnt; zero during the drain cycle.
   always_comb begin
      col_sum = '0;
      for (int cc = 0; cc < K; cc++) begin
         if (c_cnt == CW'(cc)) begin
            for (int r = 0; r < K; r++) begin
               col_sum = col_sum + mul_ext(x_q[(r*K+cc)*DW +: DW], w_q[(r*K+cc)*DW +: DW]);
            end
         end
      end
   end

   // Final result: add last pending column and bias, floor-shift, saturate, optional ReLU.
   always_comb begin
      total   = (ACCW+1)'(acc) + (ACCW+1)'(col_q) + (ACCW+1)'(bias_q);
      shifted = total >>> SHIFT;
      if (shifted > SAT_MAX) begin
         result = SAT_MAX[DW-1:0];
      end else if (shifted < SAT_MIN) begin
         result = SAT_MIN[DW-1:0];
      end else begin
         result = shifted[DW-1:0];
      end
      if (relu_q && result[DW-1]) begin
         result = '0;
      end
   end

   // Control FSM with registered handshake outputs and operand/accumulator state.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         x_ready    <= 1'b1;
         conv_valid <= 1'b0;
         conv_data  <= '0;
         c_cnt      <= '0;
         acc        <= '0;
         col_q      <= '0;
         x_q        <= '0;
         w_q        <= '0;
         bias_q     <= '0;
         relu_q     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (x_valid) begin
                  x_q     <= x_win;
                  w_q     <= w_win;
                  bias_q  <= bias;
                  relu_q  <= relu_en;
                  acc     <= '0;
                  col_q   <= '0;
                  c_cnt   <= '0;
                  x_ready <= 1'b0;
                  state   <= MAC;
               end
            end
            MAC: begin
               if (c_cnt != CW'(K)) begin
                  col_q <= col_sum;
                  acc   <= acc + col_q;
                  c_cnt <= c_cnt + CW'(1);
               end else begin
                  conv_data  <= result;
                  conv_valid <= 1'b1;
                  state      <= OUT;
               end
            end
            OUT: begin
               if (conv_ready) begin
                  conv_valid <= 1'b0;
                  x_ready    <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: begin
               state      <= IDLE;
               x_ready    <= 1'b1;
               conv_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_conv_kernel_mac.sv
// tb/tb_conv_kernel_mac.sv - directed self-checking bench for conv_kernel_mac
module tb_conv_kernel_mac;

   localparam int DW = 9;
   localparam int NA = 5*5*DW;
   localparam int NC = 3*3*DW;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic          a_x_valid, a_x_ready, a_relu_en, a_conv_valid, a_conv_ready;
   logic [NA-1:0] a_x_win, a_w_win;
   logic [DW-1:0] a_bias, a_conv_data;

   logic          b_x_valid, b_x_ready, b_relu_en, b_conv_valid, b_conv_ready;
   logic [NA-1:0] b_x_win, b_w_win;
   logic [DW-1:0] b_bias, b_conv_data;

   logic          c_x_valid, c_x_ready, c_relu_en, c_conv_valid, c_conv_ready;
   logic [NC-1:0] c_x_win, c_w_win;
   logic [DW-1:0] c_bias, c_conv_data;

   conv_kernel_mac #(.K(5), .DW(DW), .SHIFT(0)) u_a (
      .clk(clk), .rstn(rstn), .x_valid(a_x_valid), .x_ready(a_x_ready),
      .x_win(a_x_win), .w_win(a_w_win), .bias(a_bias), .relu_en(a_relu_en),
      .conv_valid(a_conv_valid), .conv_ready(a_conv_ready), .conv_data(a_conv_data));

   conv_kernel_mac #(.K(5), .DW(DW), .SHIFT(4)) u_b (
      .clk(clk), .rstn(rstn), .x_valid(b_x_valid), .x_ready(b_x_ready),
      .x_win(b_x_win), .w_win(b_w_win), .bias(b_bias), .relu_en(b_relu_en),
      .conv_valid(b_conv_valid), .conv_ready(b_conv_ready), .conv_data(b_conv_data));

   conv_kernel_mac #(.K(3), .DW(DW), .SHIFT(0)) u_c (
      .clk(clk), .rstn(rstn), .x_valid(c_x_valid), .x_ready(c_x_ready),
      .x_win(c_x_win), .w_win(c_w_win), .bias(c_bias), .relu_en(c_relu_en),
      .conv_valid(c_conv_valid), .conv_ready(c_conv_ready), .conv_data(c_conv_data));

   function automatic logic [NA-1:0] fill5(input int v);
      logic [NA-1:0] r;
      r = '0;
      for (int i = 0; i < 25; i++) r[i*DW +: DW] = DW'(v);
      return r;
   endfunction

   task automatic run_a(input logic [NA-1:0] x, input logic [NA-1:0] w, input int bi,
                        input logic re, output int lat, output logic [DW-1:0] d);
      int n;
      n = 0;
      @(negedge clk);
      while (!a_x_ready && n < 20) begin @(negedge clk); n++; end
      if (!a_x_ready) begin
         checks++; errors++;
         $display("FAIL a_ready_timeout got x_ready=%0b want 1", a_x_ready);
      end
      a_x_win = x; a_w_win = w; a_bias = DW'(bi); a_relu_en = re; a_x_valid = 1'b1;
      @(posedge clk); #1;
      a_x_valid = 1'b0; a_x_win = '1; a_w_win = '1; a_bias = '1; a_relu_en = ~re;
      lat = 0;
      while (lat < 30) begin
         @(posedge clk); #1; lat++;
         if (a_conv_valid) break;
      end
      d = a_conv_data;
   endtask

   task automatic run_b(input logic [NA-1:0] x, input logic [NA-1:0] w, input int bi,
                        input logic re, output int lat, output logic [DW-1:0] d);
      int n;
      n = 0;
      @(negedge clk);
      while (!b_x_ready && n < 20) begin @(negedge clk); n++; end
      if (!b_x_ready) begin
         checks++; errors++;
         $display("FAIL b_ready_timeout got x_ready=%0b want 1", b_x_ready);
      end
      b_x_win = x; b_w_win = w; b_bias = DW'(bi); b_relu_en = re; b_x_valid = 1'b1;
      @(posedge clk); #1;
      b_x_valid = 1'b0; b_x_win = '0; b_w_win = '0; b_bias = '0; b_relu_en = ~re;
      lat = 0;
      while (lat < 30) begin
         @(posedge clk); #1; lat++;
         if (b_conv_valid) break;
      end
      d = b_conv_data;
   endtask

   task automatic run_c(input logic [NC-1:0] x, input logic [NC-1:0] w, input int bi,
                        input logic re, output int lat, output logic [DW-1:0] d);
      int n;
      n = 0;
      @(negedge clk);
      while (!c_x_ready && n < 20) begin @(negedge clk); n++; end
      if (!c_x_ready) begin
         checks++; errors++;
         $display("FAIL c_ready_timeout got x_ready=%0b want 1", c_x_ready);
      end
      c_x_win = x; c_w_win = w; c_bias = DW'(bi); c_relu_en = re; c_x_valid = 1'b1;
      @(posedge clk); #1;
      c_x_valid = 1'b0; c_x_win = '1; c_w_win = '1; c_bias = '1; c_relu_en = ~re;
      lat = 0;
      while (lat < 30) begin
         @(posedge clk); #1; lat++;
         if (c_conv_valid) break;
      end
      d = c_conv_data;
   endtask

   task automatic test_reset;
      checks++; if (a_x_ready !== 1'b1) begin errors++; $display("FAIL reset_x_ready got %0b want 1", a_x_ready); end
      checks++; if (a_conv_valid !== 1'b0) begin errors++; $display("FAIL reset_conv_valid got %0b want 0", a_conv_valid); end
      checks++; if (a_conv_data !== '0) begin errors++; $display("FAIL reset_conv_data got %0d want 0", a_conv_data); end
      checks++; if (b_conv_valid !== 1'b0) begin errors++; $display("FAIL reset_b_valid got %0b want 0", b_conv_valid); end
      checks++; if (c_x_ready !== 1'b1) begin errors++; $display("FAIL reset_c_ready got %0b want 1", c_x_ready); end
   endtask

   task automatic test_ones;
      int lat; logic [DW-1:0] d;
      run_a(fill5(1), fill5(1), 0, 1'b0, lat, d);
      checks++; if (lat !== 6) begin errors++; $display("FAIL ones_latency got %0d want 6", lat); end
      checks++; if (d !== 9'd25) begin errors++; $display("FAIL ones_data got %0d want 25", $signed(d)); end
   endtask

   task automatic test_mixed;
      int lat; logic [DW-1:0] d; logic [NA-1:0] x, w;
      x = '0; w = '0;
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++) begin
            x[(r*5+c)*DW +: DW] = DW'(c - 2);
            w[(r*5+c)*DW +: DW] = DW'(c);
         end
      run_a(x, w, -60, 1'b0, lat, d);
      checks++; if ($signed(d) !== -9'sd10) begin errors++; $display("FAIL mixed_data got %0d want -10", $signed(d)); end
      run_a(x, w, -60, 1'b1, lat, d);
      checks++; if (d !== 9'd0) begin errors++; $display("FAIL mixed_relu got %0d want 0", $signed(d)); end
   endtask

   task automatic test_saturation;
      int lat; logic [DW-1:0] d;
      run_b(fill5(255), fill5(255), 0, 1'b0, lat, d);
      checks++; if (d !== 9'd255) begin errors++; $display("FAIL sat_pos got %0d want 255", $signed(d)); end
      checks++; if (lat !== 6) begin errors++; $display("FAIL sat_latency got %0d want 6", lat); end
      run_b(fill5(-256), fill5(255), -1, 1'b0, lat, d);
      checks++; if ($signed(d) !== -9'sd256) begin errors++; $display("FAIL sat_neg got %0d want -256", $signed(d)); end
      run_b(fill5(-256), fill5(255), -1, 1'b1, lat, d);
      checks++; if (d !== 9'd0) begin errors++; $display("FAIL sat_neg_relu got %0d want 0", $signed(d)); end
   endtask

   task automatic test_shift_floor;
      int lat; logic [DW-1:0] d;
      run_b(fill5(1), fill5(-1), 0, 1'b0, lat, d);
      checks++; if ($signed(d) !== -9'sd2) begin errors++; $display("FAIL shift_floor_neg got %0d want -2", $signed(d)); end
      run_b(fill5(1), fill5(1), 0, 1'b0, lat, d);
      checks++; if (d !== 9'd1) begin errors++; $display("FAIL shift_floor_pos got %0d want 1", $signed(d)); end
   endtask

   task automatic test_k3;
      int lat; logic [DW-1:0] d; logic [NC-1:0] x, w;
      x = '0; w = '0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++) begin
            x[(r*3+c)*DW +: DW] = DW'(r*3 + c);
            w[(r*3+c)*DW +: DW] = DW'(1);
         end
      run_c(x, w, -36, 1'b0, lat, d);
      checks++; if (d !== 9'd0) begin errors++; $display("FAIL k3_data got %0d want 0", $signed(d)); end
      checks++; if (lat !== 4) begin errors++; $display("FAIL k3_latency got %0d want 4", lat); end
      run_c(x, w, 0, 1'b0, lat, d);
      checks++; if (d !== 9'd36) begin errors++; $display("FAIL k3_sum got %0d want 36", $signed(d)); end
   endtask

   task automatic test_backpressure;
      int lat; logic [DW-1:0] d;
      a_conv_ready = 1'b0;
      run_a(fill5(1), fill5(1), 0, 1'b0, lat, d);
      checks++; if (d !== 9'd25) begin errors++; $display("FAIL bp_first_data got %0d want 25", $signed(d)); end
      a_x_win = fill5(2); a_w_win = fill5(1); a_bias = '0; a_relu_en = 1'b0; a_x_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++; if (a_conv_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_hold[%0d] got %0b want 1", i, a_conv_valid); end
         checks++; if (a_conv_data !== 9'd25) begin errors++; $display("FAIL bp_data_hold[%0d] got %0d want 25", i, $signed(a_conv_data)); end
         checks++; if (a_x_ready !== 1'b0) begin errors++; $display("FAIL bp_x_ready[%0d] got %0b want 0", i, a_x_ready); end
      end
      a_conv_ready = 1'b1;
      @(posedge clk); #1;
      checks++; if (a_conv_valid !== 1'b0) begin errors++; $display("FAIL bp_after_hs_valid got %0b want 0", a_conv_valid); end
      checks++; if (a_x_ready !== 1'b1) begin errors++; $display("FAIL bp_after_hs_ready got %0b want 1", a_x_ready); end
      @(posedge clk); #1;
      checks++; if (a_x_ready !== 1'b0) begin errors++; $display("FAIL bp_accept got x_ready=%0b want 0", a_x_ready); end
      a_x_valid = 1'b0; a_x_win = '1;
      lat = 0;
      while (lat < 30) begin
         @(posedge clk); #1; lat++;
         if (a_conv_valid) break;
      end
      checks++; if (lat !== 6) begin errors++; $display("FAIL bp_second_latency got %0d want 6", lat); end
      checks++; if (a_conv_data !== 9'd50) begin errors++; $display("FAIL bp_second_data got %0d want 50", $signed(a_conv_data)); end
   endtask

   task automatic test_reset_mid;
      int n; int seen; int lat; logic [DW-1:0] d;
      n = 0;
      @(negedge clk);
      while (!a_x_ready && n < 20) begin @(negedge clk); n++; end
      a_x_win = fill5(3); a_w_win = fill5(1); a_bias = '0; a_relu_en = 1'b0; a_x_valid = 1'b1;
      @(posedge clk); #1;
      a_x_valid = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b0;
      #1;
      checks++; if (a_conv_data !== '0) begin errors++; $display("FAIL rst_mid_async_data got %0d want 0", $signed(a_conv_data)); end
      @(posedge clk);
      @(negedge clk); rstn = 1'b1;
      @(posedge clk); #1;
      checks++; if (a_x_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_x_ready got %0b want 1", a_x_ready); end
      checks++; if (a_conv_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %0b want 0", a_conv_valid); end
      checks++; if (a_conv_data !== '0) begin errors++; $display("FAIL rst_mid_data got %0d want 0", $signed(a_conv_data)); end
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (a_conv_valid) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL rst_mid_stale got %0d valid cycles want 0", seen); end
      run_a(fill5(1), fill5(1), 0, 1'b0, lat, d);
      checks++; if (d !== 9'd25) begin errors++; $display("FAIL rst_recover_data got %0d want 25", $signed(d)); end
   endtask

   initial begin
      rstn = 1'b0;
      a_x_valid = 1'b0; a_x_win = '0; a_w_win = '0; a_bias = '0; a_relu_en = 1'b0; a_conv_ready = 1'b1;
      b_x_valid = 1'b0; b_x_win = '0; b_w_win = '0; b_bias = '0; b_relu_en = 1'b0; b_conv_ready = 1'b1;
      c_x_valid = 1'b0; c_x_win = '0; c_w_win = '0; c_bias = '0; c_relu_en = 1'b0; c_conv_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk); rstn = 1'b1;
      @(posedge clk); #1;
      test_reset();
      test_ones();
      test_mixed();
      test_saturation();
      test_shift_floor();
      test_k3();
      test_backpressure();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
